tdm_mux4: RTL and testbench
===========================

TDM_MUX4 -- requirements
Module: tdm_mux4

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every channel and of the output.
REQ-002 Reset is synchronous and active-high; one clock.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  4  per-channel request; bit k = channel k holds a beat.
REQ-006 in_data0..in_data3  input  WIDTH each  channel k payload, meaningful when in_valid[k]=1.
REQ-007 in_ready  output  4  per-channel accept; bit k high = channel k beat consumed this cycle.
REQ-008 out_valid  output  1  output register holds a beat.
REQ-009 out_data  output  WIDTH  registered payload.
REQ-010 out_sel  output  2  source channel of out_data, encoded {s1,s0}; drives the select lines of the receiving 1-to-4 demux.
REQ-011 out_ready  input  1  downstream accept; beat transfers when out_valid && out_ready.

Function
REQ-012 Block SHALL serialize four valid/ready input channels onto one output through a single output register stage.
REQ-013 Internal state: 2-bit round-robin pointer ptr plus output register (out_valid, out_data, out_sel); states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load = (~out_valid | out_ready) & (|in_valid); SHALL be combinational.
REQ-015 Grant g SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-016 in_ready SHALL equal one-hot(g) when load=1, else 4'b0000; never more than one bit set.
REQ-017 On load: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= g+1 mod 4 (3 wraps to 0).
REQ-018 out_valid && out_ready && no in_valid: out_valid <= 0; out_data, out_sel, ptr hold.
REQ-019 out_valid && ~out_ready: output register and ptr SHALL hold; in_ready = 0000.
REQ-020 Simultaneous drain and refill (FULL, out_ready=1, any in_valid): SHALL load the new beat in the same cycle; sustained throughput 1 beat/cycle.
REQ-021 Latency: accepted input beat appears on out_data exactly 1 cycle after acceptance.
REQ-022 in_data of non-granted channels SHALL not affect any state.
REQ-023 No beat SHALL be lost or duplicated; each in_ready pulse corresponds to exactly one out transfer.
REQ-024 Starvation-free: a continuously valid channel SHALL be granted within 4 loads.

Reset
REQ-025 rst=1 at a rising edge: out_valid=0, out_data=0, out_sel=2'b00, ptr=0 after that edge.
REQ-026 While rst=1, in_ready SHALL be 4'b0000 regardless of in_valid/out_ready.
REQ-027 Reset mid-operation (FULL, un-accepted beat) SHALL discard the held beat; no in_ready pulse that cycle.

Verification
REQ-028 rst=1 with in_valid=1111, out_ready=1 -> in_ready=0000; after edge out_valid=0, out_data=0, out_sel=00.
REQ-029 After reset, in_valid=0100, in_data2=8'hA5, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=A5, out_sel=10; ptr=3.
REQ-030 in_valid=1111 held, out_ready=1, data0..3=11,22,33,44 -> out_data sequence 11,22,33,44,11 on consecutive cycles, out_sel 0,1,2,3,0, no bubbles.
REQ-031 FULL, out_ready=0 for 5 cycles with in_valid=1111 -> out_data/out_sel stable, in_ready=0000; out_ready=1 -> next beat loaded same cycle.
REQ-032 Last grant channel 3 (ptr=0), in_valid=1001 -> grant channel 0, then channel 3 next load (wrap check).
REQ-033 FULL with beat from channel 1, rst pulsed 1 cycle -> out_valid=0, ptr=0 next cycle; beat never seen downstream; scoreboard counts in_ready pulses == output transfers.

Source files
------------

// File: rtl/tdm_mux4.sv
// Four-channel valid/ready time-division multiplexer with a single output register stage.
// Round-robin arbitration starts at the channel after the last one granted.
module tdm_mux4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       sel_q, sel_d;

  logic [WIDTH-1:0] chan_data [4];
  logic [1:0]       grant;
  logic             load;

  assign chan_data[0] = in_data0;
  assign chan_data[1] = in_data1;
  assign chan_data[2] = in_data2;
  assign chan_data[3] = in_data3;

  // First valid channel at or after ptr, wrapping mod 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    grant = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // Reset gates load so nothing is consumed while the block is held in reset.
  assign load = ((state_q == StEmpty) || out_ready) && (|in_valid) && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      StEmpty: begin
        if (load) state_d = StFull;
      end
      StFull: begin
        if (!load && out_ready) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
    if (load) begin
      data_d = chan_data[grant];
      sel_d  = grant;
      ptr_d  = grant + 2'd1;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = load ? (4'b0001 << grant) : 4'b0000;
    out_valid = (state_q == StFull);
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4: hand-computed grants/data plus a transfer scoreboard.
module tb_tdm_mux4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [7:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int transfers = 0;
  int discarded = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  tdm_mux4 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data0 = d0;
    in_data1 = d1;
    in_data2 = d2;
    in_data3 = d3;
  endtask

  // Check the combinational accept, clock, then check the registered output.
  task automatic beat(input string tag, input logic [3:0] exp_rdy, input logic exp_v,
                      input logic [7:0] exp_d, input logic [1:0] exp_s);
    #1;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    tick();
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
    check_eq({tag, ".out_data"}, 32'(out_data), 32'(exp_d));
    check_eq({tag, ".out_sel"}, 32'(out_sel), 32'(exp_s));
  endtask

  // Scoreboard: every accepted beat must leave exactly once, in order, unless flushed by reset.
  always @(posedge clk) begin
    logic [7:0] d;
    if (rst) begin
      discarded += exp_q.size();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        transfers++;
        if (exp_q.size() == 0) check_eq("sb.unexpected", 32'(out_data), 32'hFFFF_FFFF);
        else check_eq("sb.data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      for (int k = 0; k < 4; k++) begin
        if (in_ready[k]) begin
          pulses++;
          case (k)
            0: d = in_data0;
            1: d = in_data1;
            2: d = in_data2;
            default: d = in_data3;
          endcase
          exp_q.push_back(d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    #1;
    check_eq("rst.in_ready", 32'(in_ready), 32'h0);
    tick();
    beat("rst", 4'b0000, 1'b0, 8'h00, 2'd0);

    // Single beat from channel 2
    rst = 1'b0;
    in_valid = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    beat("one", 4'b0100, 1'b1, 8'hA5, 2'd2);

    // ptr=3 after channel 2: full request set grants 3 then rotates with no bubbles
    in_valid = 4'b1111;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    beat("rr3", 4'b1000, 1'b1, 8'h44, 2'd3);
    beat("rr0", 4'b0001, 1'b1, 8'h11, 2'd0);
    beat("rr1", 4'b0010, 1'b1, 8'h22, 2'd1);
    beat("rr2", 4'b0100, 1'b1, 8'h33, 2'd2);
    beat("rr3b", 4'b1000, 1'b1, 8'h44, 2'd3);
    beat("rr0b", 4'b0001, 1'b1, 8'h11, 2'd0);

    // Backpressure: hold for 5 cycles; changing data must not disturb the register
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_data(8'(8'hC0 + i), 8'h22, 8'(8'hE0 + i), 8'h44);
      beat("stall", 4'b0000, 1'b1, 8'h11, 2'd0);
    end
    out_ready = 1'b1;
    beat("resume", 4'b0010, 1'b1, 8'h22, 2'd1);

    // Drain with no requests: output clears, data/sel hold, ptr stays at 2
    in_valid = 4'b0000;
    beat("drain", 4'b0000, 1'b0, 8'h22, 2'd1);

    // Wrap: grant 3 leaves ptr=0, then 1001 picks 0 followed by 3
    in_valid = 4'b1000;
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    beat("g3", 4'b1000, 1'b1, 8'h44, 2'd3);
    in_valid = 4'b1001;
    beat("wrap0", 4'b0001, 1'b1, 8'h11, 2'd0);
    beat("wrap3", 4'b1000, 1'b1, 8'h44, 2'd3);

    // Reset while holding an unaccepted channel-1 beat
    in_valid = 4'b0010;
    set_data(8'h11, 8'h5A, 8'h33, 8'h44);
    beat("ld1", 4'b0010, 1'b1, 8'h5A, 2'd1);
    out_ready = 1'b0;
    rst = 1'b1;
    in_valid = 4'b1111;
    beat("midrst", 4'b0000, 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    beat("post", 4'b0001, 1'b1, 8'h11, 2'd0);

    // Final drain and accounting
    in_valid = 4'b0000;
    beat("end", 4'b0000, 1'b0, 8'h11, 2'd0);
    tick();
    check_eq("sb.discarded", 32'(discarded), 32'd1);
    check_eq("sb.empty", 32'(exp_q.size()), 32'd0);
    check_eq("sb.count", 32'(pulses - discarded), 32'(transfers));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
